// File: rtl/chip_valve_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : chip_valve_sequencer
//  Brief    : Step-table sequencer for the ChIP pneumatic valve lines and the
//             3-valve peristaltic pump. Plays back host-loaded steps and
//             returns every line to the all-closed safe state when finished
//             or aborted.
//  Revision : 1.0 - initial release
// ============================================================================
module chip_valve_sequencer #(
    parameter int VALVE_W  = 16,
    parameter int DEPTH    = 16,
    parameter int DUR_W    = 16,
    parameter int PUMP_DIV = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_we,
    input  logic [$clog2(DEPTH)-1:0]      cfg_addr,
    input  logic [VALVE_W+2+DUR_W-1:0]    cfg_wdata,
    input  logic [$clog2(DEPTH):0]        num_steps,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(DEPTH)-1:0]      step_idx,
    output logic [VALVE_W-1:0]            valve_ctrl,
    output logic [2:0]                    pump_ctrl
);

    localparam int AW   = $clog2(DEPTH);
    localparam int NW   = AW + 1;
    localparam int WW   = VALVE_W + 2 + DUR_W;
    localparam int DIVW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam logic [NW-1:0]   DEPTH_N  = NW'(DEPTH);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PUMP_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state;
    logic [WW-1:0]        mem [DEPTH];
    logic [WW-1:0]        rd_data;
    logic [AW-1:0]        rd_addr;
    logic [NW-1:0]        n_lat;
    logic [DUR_W-1:0]     dur_cnt;
    logic                 cur_en;
    logic                 cur_dir;
    logic [2:0]           phase;
    logic [DIVW-1:0]      div;

    // Decoded fields of the entry fetched for the upcoming step
    logic [DUR_W-1:0]     rd_dur;
    logic                 rd_dir;
    logic                 rd_en;
    logic [VALVE_W-1:0]   rd_mask;

    logic                 start_ok;
    logic                 more_steps;
    logic                 div_wrap;
    logic [DIVW-1:0]      div_nxt;
    logic [2:0]           phase_adv;
    logic [2:0]           phase_nxt;

    // Peristaltic valve pattern; phases 6/7 are unreachable and map to closed
    function automatic logic [2:0] pump_pattern(input logic [2:0] p);
        case (p)
            3'd0:    pump_pattern = 3'b011;
            3'd1:    pump_pattern = 3'b001;
            3'd2:    pump_pattern = 3'b101;
            3'd3:    pump_pattern = 3'b100;
            3'd4:    pump_pattern = 3'b110;
            3'd5:    pump_pattern = 3'b010;
            default: pump_pattern = 3'b111;
        endcase
    endfunction

    // While running, prefetch the next step so its entry is ready in LOAD;
    // otherwise keep entry 0 ready for the next start.
    assign rd_addr = (state == S_RUN) ? (step_idx + AW'(1)) : '0;

    assign rd_dur  = rd_data[DUR_W-1:0];
    assign rd_dir  = rd_data[DUR_W];
    assign rd_en   = rd_data[DUR_W+1];
    assign rd_mask = rd_data[VALVE_W+DUR_W+1:DUR_W+2];

    // Start qualification, step-end decision and next pump divider/phase
    always_comb begin
        start_ok   = start && !abort && (num_steps != '0) && (num_steps <= DEPTH_N);
        more_steps = (({1'b0, step_idx} + NW'(1)) < n_lat);
        div_wrap   = (div == DIV_LAST);
        div_nxt    = div_wrap ? '0 : (div + DIVW'(1));
        if (cur_dir) begin
            phase_adv = (phase == 3'd0) ? 3'd5 : (phase - 3'd1);
        end else begin
            phase_adv = (phase == 3'd5) ? 3'd0 : (phase + 3'd1);
        end
        phase_nxt = div_wrap ? phase_adv : phase;
    end

    // Step table: writable only while idle, registered read, never reset
    always_ff @(posedge clk) begin
        if (cfg_we && (state == S_IDLE)) begin
            mem[cfg_addr] <= cfg_wdata;
        end
        rd_data <= mem[rd_addr];
    end

    // Sequencer FSM with registered valve/pump outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_idx   <= '0;
            valve_ctrl <= '1;
            pump_ctrl  <= 3'b111;
            n_lat      <= '0;
            dur_cnt    <= '0;
            cur_en     <= 1'b0;
            cur_dir    <= 1'b0;
            phase      <= 3'd0;
            div        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state    <= S_LOAD;
                        busy     <= 1'b1;
                        n_lat    <= num_steps;
                        step_idx <= '0;
                        phase    <= 3'd0;
                        div      <= '0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        valve_ctrl <= '1;
                        pump_ctrl  <= 3'b111;
                    end else begin
                        state      <= S_RUN;
                        valve_ctrl <= rd_mask;
                        dur_cnt    <= (rd_dur == '0) ? DUR_W'(1) : rd_dur;
                        cur_en     <= rd_en;
                        cur_dir    <= rd_dir;
                        pump_ctrl  <= rd_en ? pump_pattern(phase) : 3'b111;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        valve_ctrl <= '1;
                        pump_ctrl  <= 3'b111;
                    end else begin
                        if (cur_en) begin
                            div   <= div_nxt;
                            phase <= phase_nxt;
                        end
                        if (dur_cnt == DUR_W'(1)) begin
                            if (more_steps) begin
                                // Outputs hold through LOAD for a glitch-free handover
                                step_idx <= step_idx + AW'(1);
                                state    <= S_LOAD;
                            end else begin
                                state      <= S_DONE;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                valve_ctrl <= '1;
                                pump_ctrl  <= 3'b111;
                            end
                        end else begin
                            dur_cnt <= dur_cnt - DUR_W'(1);
                            if (cur_en) begin
                                pump_ctrl <= pump_pattern(phase_nxt);
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chip_valve_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chip_valve_sequencer
//  Brief    : Directed self-checking bench for chip_valve_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_chip_valve_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [33:0] cfg_wdata;
    logic [4:0]  num_steps;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [3:0]  step_idx;
    logic [15:0] valve_ctrl;
    logic [2:0]  pump_ctrl;

    int checks   = 0;
    int failures = 0;

    logic [2:0] fwd  [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};
    logic [2:0] rev  [6] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
    logic [2:0] exp4 [14] = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b001, 3'b001, 3'b001,
                              3'b001, 3'b001, 3'b101, 3'b101, 3'b101, 3'b101, 3'b111};

    chip_valve_sequencer #(
        .VALVE_W  (16),
        .DEPTH    (16),
        .DUR_W    (16),
        .PUMP_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .num_steps  (num_steps),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .step_idx   (step_idx),
        .valve_ctrl (valve_ctrl),
        .pump_ctrl  (pump_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] mk(input logic [15:0] mask, input logic en,
                                       input logic dir, input logic [15:0] dur);
        mk = {mask, en, dir, dur};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [33:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    // Pulse start for one cycle; returns at the LOAD-cycle negedge
    task automatic kick(input logic [4:0] n);
        num_steps = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        num_steps = '0; start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valve", 32'(valve_ctrl), 32'hFFFF);
        check("rst_pump",  32'(pump_ctrl),  32'h7);
        check("rst_busy",  32'(busy),       32'h0);
        check("rst_done",  32'(done),       32'h0);
        check("rst_idx",   32'(step_idx),   32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-step valve program, second step with zero duration
        wr(4'd0, mk(16'h00F0, 1'b0, 1'b0, 16'd3));
        wr(4'd1, mk(16'h0001, 1'b0, 1'b0, 16'd0));
        kick(5'd2);                                   // T+1 LOAD
        check("t2_busy_load", 32'(busy), 32'h1);
        check("t2_valve_load", 32'(valve_ctrl), 32'hFFFF);
        for (int c = 0; c < 3; c++) begin             // T+2..T+4
            @(negedge clk);
            check("t2_valve_s0", 32'(valve_ctrl), 32'h00F0);
            check("t2_idx_s0",   32'(step_idx),   32'h0);
        end
        @(negedge clk);                               // T+5 LOAD
        check("t2_valve_hold", 32'(valve_ctrl), 32'h00F0);
        check("t2_idx_s1",     32'(step_idx),   32'h1);
        @(negedge clk);                               // T+6
        check("t2_valve_s1", 32'(valve_ctrl), 32'h0001);
        check("t2_done_early", 32'(done), 32'h0);
        @(negedge clk);                               // T+7 DONE
        check("t2_done",       32'(done),       32'h1);
        check("t2_valve_done", 32'(valve_ctrl), 32'hFFFF);
        check("t2_busy_done",  32'(busy),       32'h0);
        @(negedge clk);
        check("t2_done_pulse", 32'(done), 32'h0);

        // Forward pump, 24 cycles
        wr(4'd0, mk(16'h1234, 1'b1, 1'b0, 16'd24));
        kick(5'd1);
        check("t3f_pump_load", 32'(pump_ctrl), 32'h7);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            check("t3f_pump", 32'(pump_ctrl), 32'(fwd[c/4]));
            if (c == 0) check("t3f_valve", 32'(valve_ctrl), 32'h1234);
        end
        @(negedge clk);
        check("t3f_pump_done", 32'(pump_ctrl), 32'h7);
        check("t3f_done",      32'(done),      32'h1);
        @(negedge clk);

        // Reverse pump, 24 cycles
        wr(4'd0, mk(16'h1234, 1'b1, 1'b1, 16'd24));
        kick(5'd1);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            check("t3r_pump", 32'(pump_ctrl), 32'(rev[c/4]));
        end
        @(negedge clk);
        check("t3r_pump_done", 32'(pump_ctrl), 32'h7);
        @(negedge clk);

        // Two consecutive pumping steps: phase carries across LOAD
        wr(4'd0, mk(16'h0A0A, 1'b1, 1'b0, 16'd6));
        wr(4'd1, mk(16'h5050, 1'b1, 1'b0, 16'd6));
        kick(5'd2);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("t4_pump", 32'(pump_ctrl), 32'(exp4[i]));
            if (i == 7) check("t4_valve_s1", 32'(valve_ctrl), 32'h5050);
        end
        @(negedge clk);

        // Abort in second RUN cycle; write during RUN must be dropped
        wr(4'd0, mk(16'h0F0F, 1'b0, 1'b0, 16'd10));
        kick(5'd1);
        @(negedge clk);                               // T+2 RUN cycle 1
        check("t5_valve_run", 32'(valve_ctrl), 32'h0F0F);
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = mk(16'hDEAD, 1'b0, 1'b0, 16'd10);
        @(negedge clk);                               // T+3 RUN cycle 2
        cfg_we = 1'b0;
        abort  = 1'b1;
        @(negedge clk);                               // T+4
        abort  = 1'b0;
        check("t5_abort_busy",  32'(busy),       32'h0);
        check("t5_abort_valve", 32'(valve_ctrl), 32'hFFFF);
        check("t5_abort_pump",  32'(pump_ctrl),  32'h7);
        for (int c = 0; c < 3; c++) begin
            check("t5_abort_nodone", 32'(done), 32'h0);
            @(negedge clk);
        end
        kick(5'd1);
        @(negedge clk);
        check("t5_replay_valve", 32'(valve_ctrl), 32'h0F0F);
        @(negedge clk);
        check("t5_replay_valve2", 32'(valve_ctrl), 32'h0F0F);

        // Asynchronous reset mid-run, then replay of the retained table
        #1 rst_n = 1'b0;
        #1;
        check("t1_async_valve", 32'(valve_ctrl), 32'hFFFF);
        check("t1_async_pump",  32'(pump_ctrl),  32'h7);
        check("t1_async_busy",  32'(busy),       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        kick(5'd1);
        @(negedge clk);                               // T+2
        check("t1_replay_valve", 32'(valve_ctrl), 32'h0F0F);
        repeat (10) @(negedge clk);                   // T+12 DONE
        check("t1_replay_done", 32'(done), 32'h1);
        check("t1_replay_safe", 32'(valve_ctrl), 32'hFFFF);
        @(negedge clk);

        // Illegal step counts are ignored
        kick(5'd0);
        check("t6_zero_busy", 32'(busy), 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("t6_zero_nodone", 32'(done), 32'h0);
        end
        kick(5'd17);
        check("t6_over_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("t6_over_nodone", 32'(done), 32'h0);

        // start with abort in IDLE: abort wins
        num_steps = 5'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("t6_sa_busy", 32'(busy), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_sa_idle", 32'(busy), 32'h0);
            check("t6_sa_nodone", 32'(done), 32'h0);
        end

        // Full-depth program is accepted; abort during LOAD
        kick(5'd16);
        check("t6_depth_busy", 32'(busy), 32'h1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6_loadabort_busy",  32'(busy),       32'h0);
        check("t6_loadabort_valve", 32'(valve_ctrl), 32'hFFFF);
        @(negedge clk);
        check("t6_loadabort_nodone", 32'(done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
